// File: rtl/mdu_iq.sv
// In-order issue queue for the multiply/divide unit: buffers dispatched ops,
// captures late operands from the wakeup bus and issues the oldest ready op.
package mdu_iq_pkg;
    localparam logic [2:0] _MDU_MUL    = 3'd0;
    localparam logic [2:0] _MDU_MULH   = 3'd1;
    localparam logic [2:0] _MDU_MULHSU = 3'd2;
    localparam logic [2:0] _MDU_MULHU  = 3'd3;
    localparam logic [2:0] _MDU_DIV    = 3'd4;
    localparam logic [2:0] _MDU_DIVU   = 3'd5;
    localparam logic [2:0] _MDU_REM    = 3'd6;
    localparam logic [2:0] _MDU_REMU   = 3'd7;

    typedef struct packed {
        logic [4:0] rd;
        logic       rd_we;
        logic [5:0] rob_idx;
    } decode_info_t;

    typedef struct packed {
        logic [2:0]       op;
        logic [1:0][31:0] data;
    } mdu_i_t;
endpackage

module mdu_iq
    import mdu_iq_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int PREG_W = 6,
    parameter int WK_N   = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         enq_valid_i,
    output logic                         enq_ready_o,
    input  logic [2:0]                   enq_op_i,
    input  logic [1:0][PREG_W-1:0]       enq_tag_i,
    input  logic [1:0]                   enq_rdy_i,
    input  logic [1:0][31:0]             enq_data_i,
    input  decode_info_t                 enq_di_i,
    input  logic [WK_N-1:0]              wk_valid_i,
    input  logic [WK_N-1:0][PREG_W-1:0]  wk_tag_i,
    input  logic [WK_N-1:0][31:0]        wk_data_i,
    output logic                         iss_valid_o,
    input  logic                         iss_ready_i,
    output mdu_i_t                       iss_req_o,
    output decode_info_t                 iss_di_o
);
    localparam int              PTR_W    = $clog2(DEPTH);
    localparam logic [PTR_W:0]  FULL_CNT = (PTR_W + 1)'(DEPTH);

    typedef struct packed {
        logic        hit;
        logic [31:0] data;
    } wk_res_t;

    // Searches the wakeup ports for a tag; the lowest matching port index wins.
    function automatic wk_res_t wk_lookup(
        input logic [PREG_W-1:0]            tag,
        input logic [WK_N-1:0]              vld,
        input logic [WK_N-1:0][PREG_W-1:0]  wtag,
        input logic [WK_N-1:0][31:0]        wdata
    );
        wk_res_t res;
        res = '0;
        for (int k = 0; k < WK_N; k++) begin
            res = (!res.hit && vld[k] && (wtag[k] == tag)) ? {1'b1, wdata[k]} : res;
        end
        return res;
    endfunction

    logic                    valid_r [DEPTH];
    logic [2:0]              op_r    [DEPTH];
    decode_info_t            di_r    [DEPTH];
    logic [1:0][PREG_W-1:0]  tag_r   [DEPTH];
    logic [1:0]              rdy_r   [DEPTH];
    logic [1:0][31:0]        data_r  [DEPTH];
    logic [PTR_W-1:0]        head_r;
    logic [PTR_W-1:0]        tail_r;
    logic [PTR_W:0]          count_r;

    wk_res_t ent_wk_s [DEPTH][2];
    wk_res_t enq_wk_s [2];
    logic    enq_fire_s;
    logic    iss_fire_s;

    // Wakeup match results for every stored source and for the incoming op.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            for (int s = 0; s < 2; s++) begin
                ent_wk_s[i][s] = wk_lookup(tag_r[i][s], wk_valid_i, wk_tag_i, wk_data_i);
            end
        end
        for (int s = 0; s < 2; s++) begin
            enq_wk_s[s] = wk_lookup(enq_tag_i[s], wk_valid_i, wk_tag_i, wk_data_i);
        end
    end

    assign enq_ready_o = (count_r != FULL_CNT);
    assign enq_fire_s  = enq_valid_i & enq_ready_o;
    assign iss_valid_o = valid_r[head_r] & (&rdy_r[head_r]);
    assign iss_fire_s  = iss_valid_o & iss_ready_i;
    assign iss_req_o   = {op_r[head_r], data_r[head_r]};
    assign iss_di_o    = di_r[head_r];

    // Queue state: flush outranks everything; an enqueue overrides wakeup on the tail slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                valid_r[i] <= 1'b0;
                op_r[i]    <= '0;
                di_r[i]    <= '0;
                tag_r[i]   <= '0;
                rdy_r[i]   <= '0;
                data_r[i]  <= '0;
            end
        end else if (flush) begin
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                valid_r[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                for (int s = 0; s < 2; s++) begin
                    if (valid_r[i] && !rdy_r[i][s] && ent_wk_s[i][s].hit) begin
                        rdy_r[i][s]  <= 1'b1;
                        data_r[i][s] <= ent_wk_s[i][s].data;
                    end
                end
            end
            if (iss_fire_s) begin
                valid_r[head_r] <= 1'b0;
                head_r          <= head_r + PTR_W'(1);
            end
            if (enq_fire_s) begin
                valid_r[tail_r] <= 1'b1;
                op_r[tail_r]    <= enq_op_i;
                di_r[tail_r]    <= enq_di_i;
                tag_r[tail_r]   <= enq_tag_i;
                for (int s = 0; s < 2; s++) begin
                    rdy_r[tail_r][s]  <= enq_rdy_i[s] | enq_wk_s[s].hit;
                    data_r[tail_r][s] <= enq_rdy_i[s] ? enq_data_i[s] : enq_wk_s[s].data;
                end
                tail_r <= tail_r + PTR_W'(1);
            end
            case ({enq_fire_s, iss_fire_s})
                2'b10:   count_r <= count_r + (PTR_W + 1)'(1);
                2'b01:   count_r <= count_r - (PTR_W + 1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end
endmodule

// File: tb/tb_mdu_iq.sv
// Bench for mdu_iq: directed scenarios plus random traffic, every cycle
// compared against a queue-based reference model.
module tb_mdu_iq;
    import mdu_iq_pkg::*;

    localparam int DEPTH  = 4;
    localparam int PREG_W = 6;
    localparam int WK_N   = 2;

    logic                        clk = 1'b0;
    logic                        rst;
    logic                        flush;
    logic                        enq_valid;
    logic                        enq_ready;
    logic [2:0]                  enq_op;
    logic [1:0][PREG_W-1:0]      enq_tag;
    logic [1:0]                  enq_rdy;
    logic [1:0][31:0]            enq_data;
    decode_info_t                enq_di;
    logic [WK_N-1:0]             wk_valid;
    logic [WK_N-1:0][PREG_W-1:0] wk_tag;
    logic [WK_N-1:0][31:0]       wk_data;
    logic                        iss_valid;
    logic                        iss_ready;
    mdu_i_t                      iss_req;
    decode_info_t                iss_di;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0]             op;
        decode_info_t           di;
        logic [1:0][PREG_W-1:0] tag;
        logic [1:0]             rdy;
        logic [1:0][31:0]       data;
    } ent_t;
    ent_t mq[$];

    mdu_iq #(.DEPTH(DEPTH), .PREG_W(PREG_W), .WK_N(WK_N)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .enq_valid_i(enq_valid), .enq_ready_o(enq_ready), .enq_op_i(enq_op),
        .enq_tag_i(enq_tag), .enq_rdy_i(enq_rdy), .enq_data_i(enq_data), .enq_di_i(enq_di),
        .wk_valid_i(wk_valid), .wk_tag_i(wk_tag), .wk_data_i(wk_data),
        .iss_valid_o(iss_valid), .iss_ready_i(iss_ready),
        .iss_req_o(iss_req), .iss_di_o(iss_di)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        enq_valid = 1'b0;
        flush     = 1'b0;
        wk_valid  = '0;
    endtask

    task automatic enq(input logic [2:0] op, input logic [PREG_W-1:0] t0, input logic [PREG_W-1:0] t1,
                       input logic [1:0] rdy, input logic [31:0] d0, input logic [31:0] d1);
        enq_valid   = 1'b1;
        enq_op      = op;
        enq_tag[0]  = t0;
        enq_tag[1]  = t1;
        enq_rdy     = rdy;
        enq_data[0] = d0;
        enq_data[1] = d1;
        enq_di      = 12'($urandom);
    endtask

    task automatic wake(input int port, input logic [PREG_W-1:0] tag, input logic [31:0] data);
        wk_valid[port] = 1'b1;
        wk_tag[port]   = tag;
        wk_data[port]  = data;
    endtask

    // Reference model: a plain FIFO of ops advanced by the queue rules.
    task automatic model_step();
        ent_t e;
        logic iss_f;
        logic enq_f;
        if (flush) begin
            mq.delete();
            return;
        end
        iss_f = (mq.size() > 0) && (mq[0].rdy == 2'b11) && iss_ready;
        enq_f = enq_valid && (mq.size() < DEPTH);
        for (int i = 0; i < mq.size(); i++) begin
            e = mq[i];
            for (int s = 0; s < 2; s++) begin
                if (!e.rdy[s]) begin
                    for (int k = 0; k < WK_N; k++) begin
                        if (wk_valid[k] && wk_tag[k] == e.tag[s]) begin
                            e.rdy[s]  = 1'b1;
                            e.data[s] = wk_data[k];
                            break;
                        end
                    end
                end
            end
            mq[i] = e;
        end
        if (iss_f) void'(mq.pop_front());
        if (enq_f) begin
            e.op   = enq_op;
            e.di   = enq_di;
            e.tag  = enq_tag;
            e.rdy  = enq_rdy;
            e.data = enq_data;
            for (int s = 0; s < 2; s++) begin
                if (!enq_rdy[s]) begin
                    for (int k = 0; k < WK_N; k++) begin
                        if (wk_valid[k] && wk_tag[k] == enq_tag[s]) begin
                            e.rdy[s]  = 1'b1;
                            e.data[s] = wk_data[k];
                            break;
                        end
                    end
                end
            end
            mq.push_back(e);
        end
    endtask

    task automatic check_outputs();
        logic exp_valid;
        exp_valid = (mq.size() > 0) && (mq[0].rdy == 2'b11);
        chk("iss_valid", 128'(iss_valid), 128'(exp_valid));
        chk("enq_ready", 128'(enq_ready), 128'(mq.size() < DEPTH));
        if (exp_valid) begin
            chk("iss_op", 128'(iss_req.op), 128'(mq[0].op));
            chk("iss_data", 128'(iss_req.data), 128'(mq[0].data));
            chk("iss_di", 128'(iss_di), 128'(mq[0].di));
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        check_outputs();
        model_step();
        @(posedge clk);
        #1;
        idle();
    endtask

    logic [2:0] ops [4];
    mdu_i_t     saved;

    initial begin
        ops = '{_MDU_MUL, _MDU_MULH, _MDU_MULHSU, _MDU_MULHU};
        rst = 1'b1;
        iss_ready = 1'b0;
        enq_op = '0; enq_tag = '0; enq_rdy = '0; enq_data = '0; enq_di = '0;
        wk_tag = '0; wk_data = '0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 128'(iss_valid), 128'(1'b0));
        chk("rst_req", 128'(iss_req), 128'(0));
        chk("rst_di", 128'(iss_di), 128'(0));
        chk("rst_enq_ready", 128'(enq_ready), 128'(1'b1));
        rst = 1'b0;
        mq.delete();

        // Ready op into empty queue issues next cycle
        iss_ready = 1'b1;
        enq(_MDU_MUL, 6'd1, 6'd2, 2'b11, 32'd3, 32'd5);
        cycle();
        chk("mul_valid", 128'(iss_valid), 128'(1'b1));
        chk("mul_op", 128'(iss_req.op), 128'(_MDU_MUL));
        chk("mul_data", 128'(iss_req.data), {64'd0, 32'd5, 32'd3});
        cycle();
        chk("mul_drained", 128'(iss_valid), 128'(1'b0));

        // Late operand via wakeup two cycles after enqueue
        enq(_MDU_DIV, 6'd3, 6'd9, 2'b01, 32'd100, 32'd0);
        cycle();
        cycle();
        chk("div_wait", 128'(iss_valid), 128'(1'b0));
        wake(0, 6'd9, 32'h20);
        cycle();
        chk("div_woke", 128'(iss_valid), 128'(1'b1));
        chk("div_data1", 128'(iss_req.data[1]), 128'(32'h20));
        cycle();

        // Same-cycle bypass at enqueue
        enq(_MDU_DIV, 6'd3, 6'd9, 2'b01, 32'd7, 32'd0);
        wake(1, 6'd9, 32'h33);
        cycle();
        chk("bypass_valid", 128'(iss_valid), 128'(1'b1));
        chk("bypass_data1", 128'(iss_req.data[1]), 128'(32'h33));
        cycle();

        // Blocked head holds back ready younger ops
        enq(ops[0], 6'd7, 6'd1, 2'b10, 32'd0, 32'd11);
        cycle();
        for (int i = 1; i < 4; i++) begin
            enq(ops[i], 6'd1, 6'd2, 2'b11, 32'(i), 32'(i + 10));
            cycle();
        end
        repeat (2) begin
            chk("blocked_head", 128'(iss_valid), 128'(1'b0));
            cycle();
        end
        wake(0, 6'd7, 32'h77);
        cycle();
        for (int i = 0; i < 4; i++) begin
            chk("order_valid", 128'(iss_valid), 128'(1'b1));
            chk("order_op", 128'(iss_req.op), 128'(ops[i]));
            cycle();
        end
        chk("order_empty", 128'(iss_valid), 128'(1'b0));

        // Full queue refuses a fifth op; stalled head output is held
        iss_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            enq(_MDU_REM, 6'd1, 6'd2, 2'b11, 32'(i + 40), 32'(i + 50));
            cycle();
        end
        chk("full_ready", 128'(enq_ready), 128'(1'b0));
        enq(_MDU_REMU, 6'd1, 6'd2, 2'b11, 32'd99, 32'd98);
        cycle();
        chk("full_head", 128'(iss_req.data), {64'd0, 32'd50, 32'd40});
        saved = iss_req;
        repeat (3) begin
            cycle();
            chk("hold_req", 128'(iss_req), 128'(saved));
        end
        iss_ready = 1'b1;
        repeat (4) cycle();
        chk("full_drained", 128'(iss_valid), 128'(1'b0));

        // Two ports wake the same tag: port 0 wins
        enq(_MDU_MULHU, 6'd4, 6'd5, 2'b10, 32'd0, 32'd1);
        cycle();
        wake(0, 6'd4, 32'hA);
        wake(1, 6'd4, 32'hB);
        cycle();
        chk("prio_data0", 128'(iss_req.data[0]), 128'(32'hA));
        cycle();

        // Flush with concurrent enqueue and issue
        iss_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            enq(_MDU_DIVU, 6'd1, 6'd2, 2'b11, 32'(i), 32'(i));
            cycle();
        end
        iss_ready = 1'b1;
        enq(_MDU_DIVU, 6'd1, 6'd2, 2'b11, 32'hEE, 32'hEE);
        flush = 1'b1;
        cycle();
        chk("flush_valid", 128'(iss_valid), 128'(1'b0));
        chk("flush_ready", 128'(enq_ready), 128'(1'b1));
        enq(_MDU_MULHU, 6'd1, 6'd2, 2'b11, 32'h77, 32'h88);
        cycle();
        chk("post_flush_data", 128'(iss_req.data), {64'd0, 32'h88, 32'h77});
        cycle();

        // Asynchronous reset mid-cycle
        iss_ready = 1'b0;
        enq(_MDU_MUL, 6'd1, 6'd2, 2'b11, 32'd1, 32'd2);
        cycle();
        chk("pre_rst_valid", 128'(iss_valid), 128'(1'b1));
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_valid", 128'(iss_valid), 128'(1'b0));
        chk("async_rst_ready", 128'(enq_ready), 128'(1'b1));
        mq.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Random traffic against the model
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 99) < 60) begin
                enq(3'($urandom), PREG_W'($urandom_range(0, 7)), PREG_W'($urandom_range(0, 7)),
                    2'($urandom), $urandom, $urandom);
            end
            for (int k = 0; k < WK_N; k++) begin
                if ($urandom_range(0, 99) < 40) begin
                    wake(k, PREG_W'($urandom_range(0, 7)), $urandom);
                end
            end
            iss_ready = ($urandom_range(0, 99) < 70);
            flush     = ($urandom_range(0, 99) < 3);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mdu_iq.md
# mdu_iq

In-order issue queue in front of the `mdu` execution unit. It buffers multiply/divide micro-ops from dispatch and captures late source operands from the writeback wakeup bus. It presents the oldest op to `mdu` only once both operands are present. It handshakes upstream with dispatch and downstream with the `mdu` `valid_i`/`ready_o` pair, and is cleared by the pipeline flush.

## Interface
- `DEPTH`, 4, number of entries; power of two, ≥2
- `PREG_W`, 6, physical register tag width
- `WK_N`, 2, number of wakeup/writeback ports
- `clk`  in  1  clock
- `rst`  in  1  reset; one clock, asynchronous, active-high
- `flush`  in  1  synchronous pipeline flush; drops all entries
- `enq_valid_i`  in  1  dispatch offers an op
- `enq_ready_o`  out  1  queue accepts; equals not full
- `enq_op_i`  in  3  MDU opcode (`_MDU_*`)
- `enq_tag_i`  in  2×PREG_W  source tags [1:0]
- `enq_rdy_i`  in  2  source operand already valid
- `enq_data_i`  in  2×32  source values; meaningful where `enq_rdy_i` is set
- `enq_di_i`  in  decode_info_t  decode info carried with the op
- `wk_valid_i`  in  WK_N  wakeup port valid
- `wk_tag_i`  in  WK_N×PREG_W  produced tag
- `wk_data_i`  in  WK_N×32  produced value
- `iss_valid_o`  out  1  head op ready for `mdu`
- `iss_ready_i`  in  1  `mdu` ready_o
- `iss_req_o`  out  mdu_i_t  `op` and `data[1:0]` of head
- `iss_di_o`  out  decode_info_t  decode info of head

## Operation
- Circular buffer: `head`, `tail` pointers of log2(DEPTH) bits, wrap modulo DEPTH. Separate `count` of log2(DEPTH)+1 bits distinguishes full from empty.
- Per entry: valid, op, di, and per source: tag, rdy, data.
- Enqueue fires on `enq_valid_i & enq_ready_o`: writes entry at `tail`, then `tail++`.
- Source bypass at enqueue: if `enq_rdy_i[s]`=0 and any `wk_valid_i[k]` with `wk_tag_i[k]==enq_tag_i[s]` in the same cycle, the entry is written with rdy=1 and `wk_data_i[k]`.
- Wakeup: every cycle, each valid entry source with rdy=0 compares against all ports; on match it sets rdy=1 and latches the data.
- Multiple matching ports: lowest index wins.
- An already-ready source is never overwritten.
- Issue: `iss_valid_o` = head valid & both head sources rdy. Computed from registered state only, so a wakeup in cycle N is visible at the head in N+1.
- Issue fires on `iss_valid_o & iss_ready_i`: head entry invalidated, `head++`.
- Strictly in order: a not-ready head blocks all younger entries.
- `iss_req_o`/`iss_di_o` always reflect the head entry. They are held stable while `iss_valid_o & ~iss_ready_i`.
- Simultaneous enqueue and issue: both fire, `count` unchanged.
- When full, `enq_ready_o`=0 even if an issue fires in the same cycle. No full-queue pass-through.
- `flush`: all valids cleared, `head`=`tail`=`count`=0 on the next edge. Any enqueue in the flush cycle is dropped. Flush has priority over enqueue, issue and wakeup.

## Timing
- Reset (async assert): `head`=`tail`=`count`=0, all entry valid/rdy=0, data/di=0.
- Output reset values: `iss_valid_o`=0, `iss_req_o`=0, `iss_di_o`=0, `enq_ready_o`=1.
- Reset deassert is synchronised by the clock domain owner; the block itself needs no release logic.
- Latency, enqueue with both sources ready into an empty queue: accepted at edge N, `iss_valid_o`=1 in cycle N+1.
- Latency, enqueue with a missing source: wakeup at edge M, `iss_valid_o` in M+1, or N+1 if M==N via bypass.
- Throughput: one enqueue and one issue per cycle.
- Reset asserted mid-operation: state clears immediately, regardless of the clock.

## Test plan
- Reset, then enqueue `MUL` with rdy=2'b11, data 3/5 into an empty queue -> cycle+1 `iss_valid_o`=1, `iss_req_o.op`=`_MDU_MUL`, data {5,3}; `count` 0 after issue with `iss_ready_i`=1.
- Enqueue `DIV` with src1 tag 9 not ready; wakeup tag 9 value 0x20 two cycles later -> `iss_valid_o` rises the cycle after the wakeup with data[1]=0x20. Same-cycle wakeup at enqueue -> issue one cycle after enqueue.
- Head waits on tag 7 while entries 2..4 are all ready -> no issue until tag 7 wakes up. Then four issues in order on consecutive cycles with `iss_ready_i`=1.
- Fill 4 entries with `iss_ready_i`=0 -> `enq_ready_o`=0. A fifth `enq_valid_i` is not accepted, and accepted data is unchanged. Hold `iss_ready_i`=0 for 3 cycles -> `iss_req_o` stable.
- Ports 0 and 1 both wake tag 4 with values 0xA/0xB -> the waiting entry latches 0xA.
- Queue holding 3 entries, `flush` concurrent with enqueue and issue -> next cycle `iss_valid_o`=0, `enq_ready_o`=1, and later entries issue from slot 0. Async `rst` pulse mid-cycle -> `iss_valid_o` drops before the next edge.
